// File: rtl/pipe_control_unit.sv
// ---------------------------------------------------------------------------
// pipe_control_unit
//
// Decode stage control for an RV32I(+M) pipeline. Decodes one instruction per
// accepted handshake into a registered control bundle for the EX stage,
// detects load-use hazards against the bundle currently held, and blocks
// issue for MD_LAT cycles after a multi-cycle M-extension operation.
//
// Parameters
//   EN_M        1: decode RV32M (md_op) and block issue after it; 0: M-ops illegal
//   MD_LAT      1..32, cycles issue is blocked after an accepted M-op
//   ALU_CTRL_W  width of alu_control (>= 4)
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   in_valid / in_ready      decode input handshake
//   opcode, fun3, fun7       instruction fields [6:0], [14:12], [31:25]
//   rs1, rs2, rd             register addresses
//   flush                    drop the held bundle and any pending issue block
//   out_valid / out_ready    registered bundle handshake towards EX
//   reg_write .. illegal     registered single-bit controls
//   imm_sel                  0=I 1=S 2=B 3=U 4=J
//   alu_control              0 ADD 1 SUB 2 SLL 3 SLT 4 SLTU 5 XOR 6 SRL 7 SRA
//                            8 OR 9 AND 10 PASS_B
//   rd_out                   registered destination register
// ---------------------------------------------------------------------------
module pipe_control_unit #(
    parameter int EN_M       = 0,
    parameter int MD_LAT     = 4,
    parameter int ALU_CTRL_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [6:0]            opcode,
    input  logic [2:0]            fun3,
    input  logic [6:0]            fun7,
    input  logic [4:0]            rs1,
    input  logic [4:0]            rs2,
    input  logic [4:0]            rd,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  reg_write,
    output logic                  operand_a,
    output logic                  operand_b,
    output logic                  mem_to_reg,
    output logic                  load,
    output logic                  store,
    output logic                  branch,
    output logic                  jal,
    output logic                  jalr,
    output logic                  mem_en,
    output logic                  md_op,
    output logic                  illegal,
    output logic [2:0]            imm_sel,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic [4:0]            rd_out
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam logic [ALU_CTRL_W-1:0] ALU_ADD    = ALU_CTRL_W'(0);
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB    = ALU_CTRL_W'(1);
    localparam logic [ALU_CTRL_W-1:0] ALU_SLL    = ALU_CTRL_W'(2);
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT    = ALU_CTRL_W'(3);
    localparam logic [ALU_CTRL_W-1:0] ALU_SLTU   = ALU_CTRL_W'(4);
    localparam logic [ALU_CTRL_W-1:0] ALU_XOR    = ALU_CTRL_W'(5);
    localparam logic [ALU_CTRL_W-1:0] ALU_SRL    = ALU_CTRL_W'(6);
    localparam logic [ALU_CTRL_W-1:0] ALU_SRA    = ALU_CTRL_W'(7);
    localparam logic [ALU_CTRL_W-1:0] ALU_OR     = ALU_CTRL_W'(8);
    localparam logic [ALU_CTRL_W-1:0] ALU_AND    = ALU_CTRL_W'(9);
    localparam logic [ALU_CTRL_W-1:0] ALU_PASS_B = ALU_CTRL_W'(10);

    localparam logic [4:0] MD_LOAD = 5'(MD_LAT - 1);

    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } state_t;

    typedef struct packed {
        logic                  reg_write;
        logic                  operand_a;
        logic                  operand_b;
        logic                  mem_to_reg;
        logic                  load;
        logic                  store;
        logic                  branch;
        logic                  jal;
        logic                  jalr;
        logic                  mem_en;
        logic                  md_op;
        logic                  illegal;
        logic [2:0]            imm_sel;
        logic [ALU_CTRL_W-1:0] alu_control;
    } ctrl_t;

    // alt selects SUB (fun3=000) or SRA (fun3=101); ignored for other fun3.
    function automatic logic [ALU_CTRL_W-1:0] alu_of(input logic [2:0] f3,
                                                     input logic       alt);
        logic [ALU_CTRL_W-1:0] op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    state_t     state_reg, state_next;
    logic [4:0] cnt_reg, cnt_next;
    logic       out_valid_reg;
    ctrl_t      ctrl_reg;
    logic [4:0] rd_reg;

    ctrl_t      dec_next;
    logic       uses_rs1, uses_rs2, is_mop;
    logic       advance, load_use, accept;

    // ------------------------------------------------------------------
    // Combinational decode of the presented instruction
    // ------------------------------------------------------------------
    always_comb begin
        dec_next = '0;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        is_mop   = 1'b0;
        case (opcode)
            OP_R: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                if (fun7 == 7'b0000001) begin
                    if (EN_M != 0) begin
                        dec_next.reg_write = 1'b1;
                        dec_next.md_op     = 1'b1;
                        is_mop             = 1'b1;
                    end else begin
                        dec_next.illegal = 1'b1;
                    end
                end else begin
                    dec_next.reg_write   = 1'b1;
                    dec_next.alu_control = alu_of(fun3, fun7[5]);
                end
            end
            OP_I: begin
                uses_rs1             = 1'b1;
                dec_next.reg_write   = 1'b1;
                dec_next.operand_b   = 1'b1;
                dec_next.imm_sel     = IMM_I;
                // Only the shift-right immediate uses fun7[5]; ADDI never subtracts.
                dec_next.alu_control = alu_of(fun3, fun7[5] && (fun3 == 3'b101));
            end
            OP_LOAD: begin
                uses_rs1           = 1'b1;
                dec_next.reg_write = 1'b1;
                dec_next.operand_b = 1'b1;
                dec_next.load      = 1'b1;
                dec_next.imm_sel   = IMM_I;
            end
            OP_STORE: begin
                uses_rs1           = 1'b1;
                uses_rs2           = 1'b1;
                dec_next.operand_b = 1'b1;
                dec_next.store     = 1'b1;
                dec_next.imm_sel   = IMM_S;
            end
            OP_BRANCH: begin
                uses_rs1         = 1'b1;
                uses_rs2         = 1'b1;
                dec_next.branch  = 1'b1;
                dec_next.imm_sel = IMM_B;
                // Equality compares subtract; ordered compares use set-less-than.
                case (fun3[2:1])
                    2'b10:   dec_next.alu_control = ALU_SLT;
                    2'b11:   dec_next.alu_control = ALU_SLTU;
                    default: dec_next.alu_control = ALU_SUB;
                endcase
            end
            OP_JAL: begin
                dec_next.reg_write = 1'b1;
                dec_next.jal       = 1'b1;
                dec_next.operand_a = 1'b1;
                dec_next.operand_b = 1'b1;
                dec_next.imm_sel   = IMM_J;
            end
            OP_JALR: begin
                uses_rs1           = 1'b1;
                dec_next.reg_write = 1'b1;
                dec_next.jalr      = 1'b1;
                dec_next.operand_b = 1'b1;
                dec_next.imm_sel   = IMM_I;
            end
            OP_LUI: begin
                dec_next.reg_write   = 1'b1;
                dec_next.operand_b   = 1'b1;
                dec_next.imm_sel     = IMM_U;
                dec_next.alu_control = ALU_PASS_B;
            end
            OP_AUIPC: begin
                dec_next.reg_write = 1'b1;
                dec_next.operand_a = 1'b1;
                dec_next.operand_b = 1'b1;
                dec_next.imm_sel   = IMM_U;
            end
            default: begin
                dec_next.illegal = 1'b1;
            end
        endcase
        dec_next.mem_en     = dec_next.load | dec_next.store;
        dec_next.mem_to_reg = dec_next.load;
    end

    // ------------------------------------------------------------------
    // Load-use hazard: the held bundle is a load whose destination is read
    // by the presented instruction. x0 never creates a dependency.
    // ------------------------------------------------------------------
    logic [4:0] src_addr [2];
    logic [1:0] src_used;
    logic [1:0] src_hit;

    assign src_addr[0] = rs1;
    assign src_addr[1] = rs2;
    assign src_used    = {uses_rs2, uses_rs1};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            assign src_hit[gi] = src_used[gi] && (src_addr[gi] == rd_reg);
        end
    endgenerate

    assign load_use = out_valid_reg && ctrl_reg.load && (rd_reg != 5'd0) && (|src_hit);
    assign advance  = !out_valid_reg || out_ready;
    assign in_ready = !rst && advance && (state_reg == RUN) && !load_use && !flush;
    assign accept   = in_valid && in_ready;

    // ------------------------------------------------------------------
    // Output register. Holds while EX stalls; a non-accepting advance
    // leaves the fields alone and just drops out_valid (bubble).
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            ctrl_reg      <= '0;
            rd_reg        <= 5'd0;
        end else if (flush) begin
            out_valid_reg <= 1'b0;
        end else if (advance) begin
            out_valid_reg <= accept;
            if (accept) begin
                ctrl_reg <= dec_next;
                rd_reg   <= rd;
            end
        end
    end

    // ------------------------------------------------------------------
    // Issue-block FSM. Entering MD_WAIT with MD_LAT-1 and leaving the cycle
    // after the count hits 0 blocks issue for exactly MD_LAT cycles.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= RUN;
            cnt_reg   <= 5'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        if (flush) begin
            state_next = RUN;
            cnt_next   = 5'd0;
        end else begin
            case (state_reg)
                RUN: begin
                    if (accept && is_mop) begin
                        state_next = MD_WAIT;
                        cnt_next   = MD_LOAD;
                    end
                end
                MD_WAIT: begin
                    if (cnt_reg == 5'd0) begin
                        state_next = RUN;
                    end else begin
                        cnt_next = cnt_reg - 5'd1;
                    end
                end
                default: begin
                    state_next = RUN;
                    cnt_next   = 5'd0;
                end
            endcase
        end
    end

    assign out_valid   = out_valid_reg;
    assign reg_write   = ctrl_reg.reg_write;
    assign operand_a   = ctrl_reg.operand_a;
    assign operand_b   = ctrl_reg.operand_b;
    assign mem_to_reg  = ctrl_reg.mem_to_reg;
    assign load        = ctrl_reg.load;
    assign store       = ctrl_reg.store;
    assign branch      = ctrl_reg.branch;
    assign jal         = ctrl_reg.jal;
    assign jalr        = ctrl_reg.jalr;
    assign mem_en      = ctrl_reg.mem_en;
    assign md_op       = ctrl_reg.md_op;
    assign illegal     = ctrl_reg.illegal;
    assign imm_sel     = ctrl_reg.imm_sel;
    assign alu_control = ctrl_reg.alu_control;
    assign rd_out      = rd_reg;

endmodule

// File: tb/tb_pipe_control_unit.sv
// ---------------------------------------------------------------------------
// tb_pipe_control_unit
//
// Two instances share one stimulus stream: instance 0 with EN_M=1/MD_LAT=4,
// instance 1 with EN_M=0. A behavioural model tracks, per instance, the held
// bundle, its valid bit and the number of cycles issue is still blocked. A
// negedge process compares every cycle; directed sequences pin the model
// with hand-computed values, followed by a randomized run.
// ---------------------------------------------------------------------------
module tb_pipe_control_unit;

    localparam int MD_LAT = 4;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef struct packed {
        logic       reg_write;
        logic       operand_a;
        logic       operand_b;
        logic       mem_to_reg;
        logic       load;
        logic       store;
        logic       branch;
        logic       jal;
        logic       jalr;
        logic       mem_en;
        logic       md_op;
        logic       illegal;
        logic [2:0] imm_sel;
        logic [3:0] alu;
    } bundle_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [6:0] opcode = 7'd0;
    logic [2:0] fun3 = 3'd0;
    logic [6:0] fun7 = 7'd0;
    logic [4:0] rs1 = 5'd0, rs2 = 5'd0, rd = 5'd0;
    logic       flush = 1'b0;
    logic       out_ready = 1'b1;

    logic [1:0] d_in_ready, d_out_valid;
    logic [1:0] d_reg_write, d_operand_a, d_operand_b, d_mem_to_reg, d_load, d_store;
    logic [1:0] d_branch, d_jal, d_jalr, d_mem_en, d_md_op, d_illegal;
    logic [2:0] d_imm_sel [2];
    logic [3:0] d_alu [2];
    logic [4:0] d_rd [2];

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dut
            pipe_control_unit #(
                .EN_M       ((gi == 0) ? 1 : 0),
                .MD_LAT     (MD_LAT),
                .ALU_CTRL_W (4)
            ) u_dut (
                .clk         (clk),
                .rst         (rst),
                .in_valid    (in_valid),
                .in_ready    (d_in_ready[gi]),
                .opcode      (opcode),
                .fun3        (fun3),
                .fun7        (fun7),
                .rs1         (rs1),
                .rs2         (rs2),
                .rd          (rd),
                .flush       (flush),
                .out_valid   (d_out_valid[gi]),
                .out_ready   (out_ready),
                .reg_write   (d_reg_write[gi]),
                .operand_a   (d_operand_a[gi]),
                .operand_b   (d_operand_b[gi]),
                .mem_to_reg  (d_mem_to_reg[gi]),
                .load        (d_load[gi]),
                .store       (d_store[gi]),
                .branch      (d_branch[gi]),
                .jal         (d_jal[gi]),
                .jalr        (d_jalr[gi]),
                .mem_en      (d_mem_en[gi]),
                .md_op       (d_md_op[gi]),
                .illegal     (d_illegal[gi]),
                .imm_sel     (d_imm_sel[gi]),
                .alu_control (d_alu[gi]),
                .rd_out      (d_rd[gi])
            );
        end
    endgenerate

    int errors = 0;
    int checks = 0;
    bit chk_on = 1'b0;

    // Model state per instance
    bit         m_valid [2];
    bundle_t    m_bundle [2];
    logic [4:0] m_rd [2];
    int         m_block [2];
    bit         m_rst_seen = 1'b0;

    task automatic chk(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d t=%0t: got %0h expected %0h", name, k, $time, act, exp);
        end
    endtask

    function automatic bundle_t dut_bundle(input int k);
        bundle_t b;
        b = {d_reg_write[k], d_operand_a[k], d_operand_b[k], d_mem_to_reg[k], d_load[k],
             d_store[k], d_branch[k], d_jal[k], d_jalr[k], d_mem_en[k], d_md_op[k],
             d_illegal[k], d_imm_sel[k], d_alu[k]};
        return b;
    endfunction

    // Expected control bundle straight from the instruction-class rules.
    function automatic bundle_t golden(input logic [6:0] op, input logic [2:0] f3,
                                       input logic [6:0] f7, input bit en_m);
        bundle_t    b;
        logic [3:0] tab [8];
        tab = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
        b = '0;
        if (op == OP_R && f7 == 7'b0000001) begin
            if (en_m) begin
                b.reg_write = 1'b1;
                b.md_op     = 1'b1;
            end else begin
                b.illegal = 1'b1;
            end
        end else if (op == OP_R) begin
            b.reg_write = 1'b1;
            b.alu = tab[f3];
            if (f7[5] && f3 == 3'd0) b.alu = 4'd1;
            if (f7[5] && f3 == 3'd5) b.alu = 4'd7;
        end else if (op == OP_I) begin
            b.reg_write = 1'b1;
            b.operand_b = 1'b1;
            b.alu = tab[f3];
            if (f7[5] && f3 == 3'd5) b.alu = 4'd7;
        end else if (op == OP_LOAD) begin
            b.reg_write = 1'b1;
            b.operand_b = 1'b1;
            b.load      = 1'b1;
        end else if (op == OP_STORE) begin
            b.operand_b = 1'b1;
            b.store     = 1'b1;
            b.imm_sel   = 3'd1;
        end else if (op == OP_BRANCH) begin
            b.branch  = 1'b1;
            b.imm_sel = 3'd2;
            if (f3[2] == 1'b0)      b.alu = 4'd1;
            else if (f3[1] == 1'b0) b.alu = 4'd3;
            else                    b.alu = 4'd4;
        end else if (op == OP_JAL) begin
            b.reg_write = 1'b1;
            b.jal       = 1'b1;
            b.operand_a = 1'b1;
            b.operand_b = 1'b1;
            b.imm_sel   = 3'd4;
        end else if (op == OP_JALR) begin
            b.reg_write = 1'b1;
            b.jalr      = 1'b1;
            b.operand_b = 1'b1;
        end else if (op == OP_LUI) begin
            b.reg_write = 1'b1;
            b.operand_b = 1'b1;
            b.imm_sel   = 3'd3;
            b.alu       = 4'd10;
        end else if (op == OP_AUIPC) begin
            b.reg_write = 1'b1;
            b.operand_a = 1'b1;
            b.operand_b = 1'b1;
            b.imm_sel   = 3'd3;
        end else begin
            b.illegal = 1'b1;
        end
        b.mem_en     = b.load | b.store;
        b.mem_to_reg = b.load;
        return b;
    endfunction

    function automatic bit reads_rs1(input logic [6:0] op);
        return op == OP_R || op == OP_I || op == OP_LOAD || op == OP_STORE ||
               op == OP_BRANCH || op == OP_JALR;
    endfunction

    function automatic bit reads_rs2(input logic [6:0] op);
        return op == OP_R || op == OP_STORE || op == OP_BRANCH;
    endfunction

    function automatic bit model_ready(input int k);
        bit hazard;
        hazard = m_valid[k] && m_bundle[k].load && m_rd[k] != 5'd0 &&
                 ((reads_rs1(opcode) && rs1 == m_rd[k]) ||
                  (reads_rs2(opcode) && rs2 == m_rd[k]));
        return !rst && (!m_valid[k] || out_ready) && m_block[k] == 0 && !hazard && !flush;
    endfunction

    // Advance the model across one rising edge using the inputs held there.
    task automatic model_update();
        bit rdy, acc, adv;
        for (int k = 0; k < 2; k++) begin
            rdy = model_ready(k);
            acc = in_valid && rdy;
            adv = !m_valid[k] || out_ready;
            if (rst) begin
                m_valid[k]  = 1'b0;
                m_bundle[k] = '0;
                m_rd[k]     = 5'd0;
                m_block[k]  = 0;
            end else if (flush) begin
                m_valid[k] = 1'b0;
                m_block[k] = 0;
            end else begin
                if (m_block[k] > 0) m_block[k]--;
                if (adv) begin
                    m_valid[k] = acc;
                    if (acc) begin
                        m_bundle[k] = golden(opcode, fun3, fun7, k == 0);
                        m_rd[k]     = rd;
                        if (m_bundle[k].md_op) m_block[k] = MD_LAT;
                        $display("t=%0t inst%0d accept op=%b f3=%0d f7=%h rs1=%0d rs2=%0d rd=%0d",
                                 $time, k, opcode, fun3, fun7, rs1, rs2, rd);
                    end
                end
            end
        end
        m_rst_seen = rst;
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                             input logic [4:0] a, input logic [4:0] b, input logic [4:0] d);
        opcode = op; fun3 = f3; fun7 = f7; rs1 = a; rs2 = b; rd = d;
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_on) begin
            for (int k = 0; k < 2; k++) begin
                chk("in_ready", k, d_in_ready[k], model_ready(k));
                chk("out_valid", k, d_out_valid[k], m_valid[k]);
                if (m_valid[k]) begin
                    chk("bundle", k, dut_bundle(k), m_bundle[k]);
                    chk("rd_out", k, d_rd[k], m_rd[k]);
                end
                if (m_rst_seen) chk("reset_zero", k, {dut_bundle(k), d_rd[k]}, 32'd0);
            end
        end
    end

    logic [6:0] op_tab [11];

    initial begin
        op_tab = '{OP_R, OP_I, OP_LOAD, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR,
                   OP_LUI, OP_AUIPC, 7'b1111111};

        // Reset
        rst = 1'b1;
        tick();
        chk_on = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst_in_ready", k, d_in_ready[k], 0);
            chk("rst_out_valid", k, d_out_valid[k], 0);
            chk("rst_bundle", k, dut_bundle(k), 0);
        end
        tick();

        // ADD x3,x1,x2
        rst = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
        set_instr(OP_R, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3);
        @(negedge clk);
        chk("add_in_ready", 0, d_in_ready[0], 1);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("add_out_valid", 0, d_out_valid[0], 1);
        chk("add_reg_write", 0, d_reg_write[0], 1);
        chk("add_alu", 0, d_alu[0], 0);
        chk("add_rd", 0, d_rd[0], 3);

        // LW x5 then ADD x6,x5,x1
        in_valid = 1'b1;
        set_instr(OP_LOAD, 3'd2, 7'd0, 5'd1, 5'd0, 5'd5);
        tick();
        set_instr(OP_R, 3'd0, 7'd0, 5'd5, 5'd1, 5'd6);
        @(negedge clk);
        chk("lu_stall", 0, d_in_ready[0], 0);
        chk("lu_load", 0, d_load[0], 1);
        tick();
        @(negedge clk);
        chk("lu_bubble", 0, d_out_valid[0], 0);
        chk("lu_resume", 0, d_in_ready[0], 1);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("lu_add_valid", 0, d_out_valid[0], 1);
        chk("lu_add_rd", 0, d_rd[0], 6);

        // MUL x7,x1,x2 followed by a continuously offered ADD x8
        in_valid = 1'b1;
        set_instr(OP_R, 3'd0, 7'b0000001, 5'd1, 5'd2, 5'd7);
        tick();
        set_instr(OP_R, 3'd0, 7'd0, 5'd1, 5'd2, 5'd8);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            chk($sformatf("mul_block_t+%0d", i), 0, d_in_ready[0], (i == 5) ? 1 : 0);
            if (i == 1) begin
                chk("mul_md_op", 0, d_md_op[0], 1);
                chk("mul_illegal_n", 1, d_illegal[1], 1);
                chk("mul_rw_n", 1, d_reg_write[1], 0);
                chk("mul_run_n", 1, d_in_ready[1], 1);
            end
            tick();
        end

        // Stall with bundle held, then flush
        set_instr(OP_I, 3'd0, 7'd0, 5'd2, 5'd0, 5'd9);
        @(negedge clk);
        chk("addi_ready", 0, d_in_ready[0], 1);
        tick();
        out_ready = 1'b0;
        set_instr(OP_LUI, 3'd0, 7'd0, 5'd0, 5'd0, 5'd10);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                chk("hold_ready", k, d_in_ready[k], 0);
                chk("hold_valid", k, d_out_valid[k], 1);
                chk("hold_rd", k, d_rd[k], 9);
            end
            tick();
        end
        flush = 1'b1;
        @(negedge clk);
        chk("flush_ready", 0, d_in_ready[0], 0);
        tick();
        flush = 1'b0;
        @(negedge clk);
        chk("flush_valid", 0, d_out_valid[0], 0);
        chk("flush_valid", 1, d_out_valid[1], 0);

        // Reset during MD_WAIT
        out_ready = 1'b1;
        set_instr(OP_R, 3'd0, 7'b0000001, 5'd1, 5'd2, 5'd7);
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_md_ready", 0, d_in_ready[0], 0);
        tick();
        rst = 1'b0;
        in_valid = 1'b1;
        set_instr(OP_R, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("post_rst_valid", k, d_out_valid[k], 0);
            chk("post_rst_bundle", k, {dut_bundle(k), d_rd[k]}, 0);
            chk("post_rst_ready", k, d_in_ready[k], 1);
        end
        tick();

        // Randomized run
        for (int c = 0; c < 1500; c++) begin
            rst       = ($urandom_range(0, 199) == 0);
            flush     = ($urandom_range(0, 39) == 0);
            in_valid  = ($urandom_range(0, 9) < 8);
            out_ready = ($urandom_range(0, 3) != 0);
            opcode    = op_tab[$urandom_range(0, 10)];
            fun3      = 3'($urandom);
            case ($urandom_range(0, 3))
                0:       fun7 = 7'd0;
                1:       fun7 = 7'h20;
                2:       fun7 = 7'h01;
                default: fun7 = 7'($urandom);
            endcase
            rs1 = 5'($urandom_range(0, 7));
            rs2 = 5'($urandom_range(0, 7));
            rd  = 5'($urandom_range(0, 7));
            tick();
        end

        @(negedge clk);
        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
